// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch geometry, reset PC, the NOP encoding
// and the fetch-state enum that the hazard unit also decodes.
package mips_pkg;

    localparam int unsigned ADDR_WIDTH  = 10;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned RESET_PC    = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous InstMem address
// and hands {pc, instruction, valid} to decode with stall/redirect handling.
module if_stage #(
    parameter int unsigned ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = mips_pkg::INSTR_WIDTH,
    parameter int unsigned RESET_PC   = mips_pkg::RESET_PC
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_q,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  redirect_ack,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [ADDR_WIDTH-1:0] if_pc_plus4,
    output logic                  if_valid,
    output logic                  misalign_err,
    output logic [31:0]           fetch_count
);

    localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] NOP      = DATA_WIDTH'(mips_pkg::NOP_INSTR);

    mips_pkg::fetch_state_e r_state;
    mips_pkg::fetch_state_e w_state_next;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_target_aligned;
    logic                  r_misalign_err;
    logic [31:0]           r_fetch_count;
    logic                  w_run;
    logic                  w_accept;

    assign w_run            = (r_state == mips_pkg::RUN);
    assign w_accept         = w_run && !stall && redirect_valid;
    assign w_pc_plus4       = r_pc + PC_STEP;
    assign w_target_aligned = {redirect_target[ADDR_WIDTH-1:2], 2'b00};

    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            mips_pkg::BOOT: begin
                w_state_next = mips_pkg::RUN;
            end
            mips_pkg::RUN: begin
                if (!stall) begin
                    w_pc_next = redirect_valid ? w_target_aligned : w_pc_plus4;
                end
            end
        endcase
    end

    // The memory registers this address on the same edge that loads r_pc,
    // so imem_q always belongs to r_pc afterwards.
    assign imem_address = reset_n ? w_pc_next : PC_RESET;

    // NOTE: state is updated with non-blocking assignments so all registers
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= mips_pkg::BOOT;
            r_pc           <= PC_RESET;
            r_misalign_err <= 1'b0;
            r_fetch_count  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_accept && (redirect_target[1:0] != 2'b00)) begin
                r_misalign_err <= 1'b1;
            end
            if (w_run && !stall) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign redirect_ack = w_accept;
    assign if_valid     = w_run;
    assign if_instr     = w_run ? imem_q : NOP;
    assign if_pc        = r_pc;
    assign if_pc_plus4  = w_pc_plus4;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;

endmodule : if_stage
